// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU front end: widths, opcode
// field constants, the NOP substituted on a fetch timeout, and the fetch
// FSM state type.
package cpu_pkg;

    localparam int AW = 13;
    localparam int DW = 8;

    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_DI  = 3'b111;

    // Opcode 111 with a zero operand field: executes as a harmless no-op.
    localparam logic [7:0] NOP_INSTR = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns PC, IR, TR and DI, performs one
// handshaked byte read per accepted IR/TR write strobe, and substitutes a
// NOP (with a sticky bus error) when memory fails to answer in time.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int AW      = cpu_pkg::AW,
    parameter int DW      = cpu_pkg::DW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_inc,
    input  logic          pc_or_tr,
    input  logic          pc_load_en,
    input  logic          ir_write_en,
    input  logic          tr_write_en,
    input  logic          di_load_en,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] tr,
    output logic [4:0]    di,
    output logic [AW-1:0] op_addr,
    output logic          busy,
    output logic          bus_err
);

    // Wait counter value in the final REQ cycle before giving up.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t  state_reg;
    logic          tgt_ir_reg;    // 1: fetch targets IR, 0: TR
    logic          inc_reg;       // apply PC+1 when the fetch completes
    logic [AW-1:0] addr_reg;      // address held for the whole request
    logic [7:0]    cnt_reg;       // REQ cycles elapsed without an ack

    // Operand / jump address formed from the low IR bits and the second byte.
    assign op_addr = {ir[4:0], tr};

    // Address follows the select while idle, then stays frozen for the fetch.
    assign mem_addr = (state_reg == IDLE) ? (pc_or_tr ? pc : op_addr) : addr_reg;

    // Fetch FSM and architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            tgt_ir_reg <= 1'b0;
            inc_reg    <= 1'b0;
            addr_reg   <= '0;
            cnt_reg    <= '0;
            mem_req    <= 1'b0;
            busy       <= 1'b0;
            bus_err    <= 1'b0;
            pc         <= '0;
            ir         <= '0;
            tr         <= '0;
            di         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pc_load_en) begin
                        pc <= op_addr;
                    end
                    if (di_load_en) begin
                        di <= ir[4:0];
                    end
                    if (ir_write_en || tr_write_en) begin
                        tgt_ir_reg <= ir_write_en;
                        // A simultaneous jump owns the PC; drop the increment.
                        inc_reg    <= pc_inc & ~pc_load_en;
                        addr_reg   <= pc_or_tr ? pc : op_addr;
                        cnt_reg    <= '0;
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack || (cnt_reg == CNT_LAST)) begin
                        if (tgt_ir_reg) begin
                            ir <= mem_ack ? mem_rdata : DW'(NOP_INSTR);
                        end else begin
                            tr <= mem_ack ? mem_rdata : DW'(NOP_INSTR);
                        end
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                        end
                        if (inc_reg) begin
                            pc <= pc + AW'(1);
                        end
                        mem_req   <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    mem_req   <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait and late fetches, jumps,
// PC wrap, load/fetch collision, timeout NOP and commands while busy.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_inc = 1'b0;
    logic        pc_or_tr = 1'b0;
    logic        pc_load_en = 1'b0;
    logic        ir_write_en = 1'b0;
    logic        tr_write_en = 1'b0;
    logic        di_load_en = 1'b0;
    logic [12:0] mem_addr;
    logic        mem_req;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [12:0] pc;
    logic [7:0]  ir;
    logic [7:0]  tr;
    logic [4:0]  di;
    logic [12:0] op_addr;
    logic        busy;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc;
    logic [12:0] raddr;

    fetch_unit #(.AW(13), .DW(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .pc_inc(pc_inc), .pc_or_tr(pc_or_tr),
        .pc_load_en(pc_load_en), .ir_write_en(ir_write_en),
        .tr_write_en(tr_write_en), .di_load_en(di_load_en),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc(pc), .ir(ir), .tr(tr), .di(di),
        .op_addr(op_addr), .busy(busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // One fetch: command in an idle cycle, optional ack after 'delay' wait
    // cycles (-1 = never), optional stray commands in the first REQ cycle.
    // Returns at the negedge of the DONE cycle.
    task automatic do_fetch(input logic to_ir, input logic to_tr, input logic inc,
                            input logic use_pc, input logic load, input logic poke,
                            input int delay, input logic [7:0] data,
                            output int n, output logic [12:0] req_addr);
        @(negedge clk);
        ir_write_en = to_ir;
        tr_write_en = to_tr;
        pc_inc      = inc;
        pc_or_tr    = use_pc;
        pc_load_en  = load;
        @(negedge clk);
        ir_write_en = 1'b0;
        tr_write_en = 1'b0;
        pc_inc      = 1'b0;
        pc_load_en  = 1'b0;
        req_addr    = mem_addr;
        if (poke) begin
            pc_load_en  = 1'b1;
            ir_write_en = 1'b1;
        end
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            if (delay >= 0 && n == delay + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = data;
            end
            @(negedge clk);
            mem_ack     = 1'b0;
            pc_load_en  = 1'b0;
            ir_write_en = 1'b0;
        end
    endtask

    task automatic jump(input logic di_too);
        @(negedge clk);
        pc_load_en = 1'b1;
        di_load_en = di_too;
        @(negedge clk);
        pc_load_en = 1'b0;
        di_load_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_pc", pc, 0);
        check("reset_ir", ir, 0);
        check("reset_busy", busy, 0);
        check("reset_req", mem_req, 0);
        rst = 1'b0;

        // Reset asserted mid-REQ, then a late ack after release.
        @(negedge clk);
        ir_write_en = 1'b1;
        pc_or_tr    = 1'b1;
        @(negedge clk);
        ir_write_en = 1'b0;
        check("midreq_req", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_req_drop", mem_req, 0);
        check("rst_busy_drop", busy, 0);
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_bus_err", bus_err, 0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_ir", ir, 0);
        check("late_ack_busy", busy, 0);
        check("late_ack_req", mem_req, 0);

        // TR <= 0x05, then jump to 0x0005.
        do_fetch(0, 1, 0, 1, 0, 0, 0, 8'h05, ncyc, raddr);
        check("tr_05", tr, 8'h05);
        jump(0);
        check("pc_0005", pc, 13'h0005);

        // Zero-wait fetch into IR with increment.
        do_fetch(1, 0, 1, 1, 0, 0, 0, 8'h3A, ncyc, raddr);
        check("zw_addr", raddr, 13'h0005);
        check("zw_cycles", ncyc, 1);
        check("zw_ir", ir, 8'h3A);
        check("zw_pc", pc, 13'h0006);
        check("zw_done_busy", busy, 1);
        check("zw_done_req", mem_req, 0);
        @(negedge clk);
        check("zw_t3_busy", busy, 0);

        // Late ack (4 wait cycles) into TR.
        do_fetch(0, 1, 1, 1, 0, 0, 4, 8'h7F, ncyc, raddr);
        check("late_cycles", ncyc, 5);
        check("late_tr", tr, 8'h7F);
        check("late_pc", pc, 13'h0007);
        check("late_op_addr", op_addr, 13'h1A7F);

        // Jump to 0x0310 with DI load.
        do_fetch(1, 0, 1, 1, 0, 0, 0, 8'hC3, ncyc, raddr);
        do_fetch(0, 1, 1, 1, 0, 0, 0, 8'h10, ncyc, raddr);
        check("pc_0009", pc, 13'h0009);
        check("op_0310", op_addr, 13'h0310);
        jump(1);
        check("jmp_pc", pc, 13'h0310);
        check("jmp_di", di, 5'h03);

        // Jump to 0x1FFF, then increment wraps to 0.
        do_fetch(1, 0, 1, 1, 0, 0, 1, 8'hFF, ncyc, raddr);
        do_fetch(0, 1, 1, 1, 0, 0, 0, 8'hFF, ncyc, raddr);
        check("pc_0312", pc, 13'h0312);
        jump(0);
        check("pc_1fff", pc, 13'h1FFF);
        do_fetch(1, 0, 1, 1, 0, 0, 0, 8'h3A, ncyc, raddr);
        check("wrap_addr", raddr, 13'h1FFF);
        check("wrap_pc", pc, 13'h0000);

        // Jump and incrementing fetch in the same cycle: load wins.
        do_fetch(1, 0, 1, 1, 1, 0, 0, 8'h00, ncyc, raddr);
        check("coll_addr", raddr, 13'h0000);
        check("coll_pc", pc, 13'h1AFF);
        check("coll_ir", ir, 8'h00);

        // IR and TR strobes together, address from op_addr: IR wins.
        do_fetch(1, 1, 0, 0, 0, 0, 0, 8'h55, ncyc, raddr);
        check("both_addr", raddr, 13'h00FF);
        check("both_ir", ir, 8'h55);
        check("both_tr", tr, 8'hFF);

        // Timeout: no ack.
        do_fetch(1, 0, 1, 1, 0, 0, -1, 8'h00, ncyc, raddr);
        check("to_req_cycles", ncyc, 15);
        check("to_ir_nop", ir, 8'hE0);
        check("to_bus_err", bus_err, 1);
        check("to_pc", pc, 13'h1B00);

        // Good fetch with stray commands during REQ.
        do_fetch(0, 1, 0, 1, 0, 1, 0, 8'h10, ncyc, raddr);
        check("poke_tr", tr, 8'h10);
        check("poke_pc", pc, 13'h1B00);
        check("poke_ir", ir, 8'hE0);
        check("sticky_bus_err", bus_err, 1);
        @(negedge clk);
        check("poke_idle_busy", busy, 0);
        check("poke_idle_req", mem_req, 0);
        @(negedge clk);
        check("poke_no_second_req", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the multicycle CPU, sitting directly upstream of the controller. It owns PC, IR, TR and DI, fetches instruction bytes from a handshaked byte memory on the controller's irWriteEn/trWriteEn strobes, and drives the controller's IR/DI inputs. It also forms operand and jump addresses `{IR[4:0], TR}`. A wait-state counter turns an unanswered fetch into a NOP instead of a hang.

## Interface
- `AW`, default 13: address width; must equal 5 + DW.
- `DW`, default 8: instruction/data byte width.
- `TIMEOUT`, default 15: maximum cycles `mem_req` waits for `mem_ack`; range 1..255.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_inc`  in  1  increment PC on completion of the accepted fetch.
- `pc_or_tr`  in  1  1: `mem_addr` = PC; 0: `mem_addr` = `op_addr`.
- `pc_load_en`  in  1  PC <= `op_addr` (jump).
- `ir_write_en`  in  1  fetch byte into IR.
- `tr_write_en`  in  1  fetch byte into TR.
- `di_load_en`  in  1  DI <= IR[4:0].
- `mem_addr`  out  AW  memory address.
- `mem_req`  out  1  read request.
- `mem_rdata`  in  DW  read data; valid with `mem_ack`.
- `mem_ack`  in  1  request completion.
- `pc`  out  AW  program counter.
- `ir`  out  DW  instruction register; feeds controller IrToCU.
- `tr`  out  DW  temporary (second-byte) register.
- `di`  out  5  immediate/direct field; feeds controller DiToCU.
- `op_addr`  out  AW  `{ir[4:0], tr}`.
- `busy`  out  1  fetch in progress; commands are ignored while high.
- `bus_err`  out  1  sticky; set on timeout; cleared only by `rst`.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE.** `ir_write_en` or `tr_write_en` is accepted. If both are high, IR wins and `tr_write_en` is dropped.
  - On acceptance, latch the target (IR/TR), `pc_inc`, and the address. The address is PC if `pc_or_tr` = 1, otherwise `op_addr`.
  - Go to REQ.
- **REQ.**
  - `mem_req` = 1; `mem_addr` holds the latched address.
  - The wait counter counts up from 0.
  - On `mem_ack`: target <= `mem_rdata`. If `pc_inc` was latched, PC <= PC+1, wrapping modulo 2^AW. Go to DONE.
  - If the counter reaches TIMEOUT with no ack: target <= `NOP_INSTR` (8'hE0, opcode 111), `bus_err` <= 1, PC increment applied as for an ack. Go to DONE.
- **DONE.** One cycle, `busy` = 1, `mem_req` = 0. Then go to IDLE.
- **PC load.** `pc_load_en` is honoured in IDLE only, in a single cycle.
  - If the same cycle also accepts a fetch with `pc_inc`, the load wins. The fetch still uses the pre-load PC and its increment is cancelled.
- **DI load.** `di_load_en` is honoured in IDLE only, single cycle; it may coincide with a fetch accept.
- **Combinational outputs.** In IDLE, `mem_addr` follows `pc_or_tr` combinationally; in REQ/DONE it is the latched address. `op_addr` is combinational from `ir`/`tr`.
- **Reset.** `pc`, `ir`, `tr`, `di`, `mem_req`, `busy`, `bus_err` and the counter all go to 0; state goes to IDLE. Mid-fetch, `mem_req` drops immediately and any late `mem_ack` after reset release in IDLE is ignored.

## Timing
- Accept at edge t, with `busy` = 0 in cycle t.
- REQ occupies cycle t+1 onward; `mem_req` is registered and high from t+1.
- Zero-wait-state ack in t+1: target and PC update at the end of t+1. DONE is cycle t+2 and `busy` is low at t+3. Minimum fetch = 3 cycles from command to next accept.
- Ack arriving k cycles late adds k cycles.
- Timeout: with no ack, `mem_req` stays high for exactly TIMEOUT cycles. The NOP and `bus_err` are registered at the end of the last one.
- `busy` is 1 in REQ and DONE and registered-equivalent; there is no combinational path from `mem_ack` to `busy`.
- `pc_load_en` and `di_load_en` take effect at the clock edge of the cycle in which they are asserted.

## Structure
- Shared package `cpu_pkg` holds:
  - `AW`, `DW`.
  - Opcode field constants `OP_JMP` = 3'b110 and `OP_DI` = 3'b111.
  - `NOP_INSTR` = 8'hE0.
  - The FSM state enum `fetch_state_t`.
- No sub-module; the wait counter is inline.

## Test plan
- **Reset.** Assert `rst` mid-REQ → `mem_req`/`busy` drop in the same cycle; `pc`=0, `ir`=0, `bus_err`=0.
- **Zero-wait fetch.** Fetch at PC=0x0005 with `pc_inc`, ack in the first REQ cycle with data 0x3A → `ir`=0x3A, `pc`=0x0006 at t+2, `busy` low at t+3.
- **Late ack into TR.** `tr_write_en` with `pc_inc`, ack after 4 wait cycles with 0x7F → `tr`=0x7F; `op_addr`={`ir`[4:0],0x7F}.
- **Jump.** `ir`=0xC3, `tr`=0x10, `pc_load_en` → `pc`=0x0310 next cycle. Repeat with PC at 0x1FFF and `pc_inc` → PC wraps to 0x0000.
- **Timeout.** TIMEOUT=15, no ack → `mem_req` high exactly 15 cycles, `ir`=0xE0, `bus_err`=1 and sticky across later good fetches.
- **Commands while busy.** Assert `pc_load_en`/`ir_write_en` during REQ → ignored; PC unchanged, no second request.
